oe_port_allocator: RTL and testbench

//  Output-side consumer of the odd-even route computation in each NoC router. One

---
 rtl/oe_port_allocator.sv | 148 ++++++++++++++
 tb/tb_oe_port_allocator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oe_port_allocator.sv
// ---------------------------------------------------------------------------
// oe_port_allocator
// Output-side allocator for one direction of an odd-even NoC router. It
// collects the requests for this output from all input ports and picks one
// by round-robin. It then locks the output to that input from head flit to
// tail flit, and lets flits through only while the downstream buffer has room.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous, active-low reset
//   in_valid    [NPORT]    flit valid at each input port
//   in_tail     [NPORT]    flit at each input port is a packet tail
//   route       [5*NPORT]  one-hot direction request of port i at [5i+4:5i]
//   credit_in   one downstream buffer slot freed this cycle
//   grant       [NPORT]    one-hot; the selected input may move a flit now
//   out_valid   a flit crosses the switch to this output this cycle
//   out_sel     [SW]       crossbar select, index of the locked input
//   credit_cnt  [CW]       downstream credits currently available
//   cred_err    sticky credit-overflow flag
// ---------------------------------------------------------------------------
module oe_port_allocator #(
    parameter int NPORT    = 5,
    parameter int MY_DIR   = 0,
    parameter int CREDITS  = 4,
    parameter int CW       = 3,
    parameter int INF_CRED = 0,
    localparam int SW      = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NPORT-1:0]   in_valid,
    input  logic [NPORT-1:0]   in_tail,
    input  logic [5*NPORT-1:0] route,
    input  logic               credit_in,
    output logic [NPORT-1:0]   grant,
    output logic               out_valid,
    output logic [SW-1:0]      out_sel,
    output logic [CW-1:0]      credit_cnt,
    output logic               cred_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CW-1:0] CRED_INIT = CW'(CREDITS);

    state_t           state;
    logic [SW-1:0]    rr_ptr;
    logic [NPORT-1:0] req;
    logic [SW-1:0]    winner;
    logic             any_req;
    logic             can_send;
    logic             fire;

    // Only the route bit for this output matters; the other four directions
    // belong to sibling allocators and are deliberately ignored here.
    logic unused_route;
    assign unused_route = ^route;

    // Requests for this output: a valid flit whose route points our way.
    always_comb begin
        req = '0;
        for (int i = 0; i < NPORT; i++) begin
            req[i] = in_valid[i] & route[5*i + MY_DIR];
        end
    end

    assign any_req = |req;

    // Round-robin search starting just after the last owner, wrapping around.
    // The last candidate examined is rr_ptr itself, so the previous owner has
    // lowest priority.
    always_comb begin
        logic          found;
        logic [SW-1:0] idx;
        found  = 1'b0;
        idx    = '0;
        winner = '0;
        for (int k = 1; k <= NPORT; k++) begin
            idx = SW'((int'(rr_ptr) + k) % NPORT);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // While locked, the owner may move a flit whenever a downstream slot is
    // free. The grant does not wait for in_valid, so the input port can use
    // it combinationally in the same cycle.
    assign can_send  = (INF_CRED != 0) || (credit_cnt != '0);
    assign fire      = (state == LOCKED) && can_send && in_valid[out_sel];
    assign out_valid = fire;
    assign grant     = ((state == LOCKED) && can_send)
                       ? (NPORT'(1) << out_sel) : '0;

    // Packet lock FSM. out_sel doubles as the owner register. Arbitration
    // happens in IDLE and costs one bubble cycle per packet. The tail flit
    // releases the lock and makes the finishing owner the new rr_ptr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            out_sel <= '0;
            rr_ptr  <= SW'(NPORT - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        out_sel <= winner;
                        state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (fire && in_tail[out_sel]) begin
                        state  <= IDLE;
                        rr_ptr <= out_sel;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream credit tracking. A sent flit consumes a slot and a returned
    // credit frees one. When both happen together, the count is unchanged.
    // A credit returned while already full would overflow, so it is dropped
    // and flagged. The eject port has an always-ready sink, so its counter
    // stays frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_cnt <= CRED_INIT;
            cred_err   <= 1'b0;
        end else if (INF_CRED == 0) begin
            if (fire && !credit_in) begin
                credit_cnt <= credit_cnt - CW'(1);
            end else if (!fire && credit_in) begin
                if (credit_cnt == CRED_INIT) begin
                    cred_err <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_oe_port_allocator.sv
// ---------------------------------------------------------------------------
// tb_oe_port_allocator
// Directed bench for oe_port_allocator. It instantiates two copies that share
// the same inputs:
//   dut    : MY_DIR=0, CREDITS=4, finite credits
//   dut_ej : MY_DIR=4, INF_CRED=1, eject port with an always-ready sink
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_oe_port_allocator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  in_valid;
    logic [4:0]  in_tail;
    logic [24:0] route;
    logic        credit_in;

    logic [4:0]  grant;
    logic        out_valid;
    logic [2:0]  out_sel;
    logic [2:0]  credit_cnt;
    logic        cred_err;

    logic [4:0]  ej_grant;
    logic        ej_out_valid;
    logic [2:0]  ej_out_sel;
    logic [2:0]  ej_credit_cnt;
    logic        ej_cred_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    oe_port_allocator #(
        .NPORT(5), .MY_DIR(0), .CREDITS(4), .CW(3), .INF_CRED(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_tail(in_tail),
        .route(route), .credit_in(credit_in), .grant(grant),
        .out_valid(out_valid), .out_sel(out_sel), .credit_cnt(credit_cnt),
        .cred_err(cred_err)
    );

    oe_port_allocator #(
        .NPORT(5), .MY_DIR(4), .CREDITS(4), .CW(3), .INF_CRED(1)
    ) dut_ej (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_tail(in_tail),
        .route(route), .credit_in(credit_in), .grant(ej_grant),
        .out_valid(ej_out_valid), .out_sel(ej_out_sel),
        .credit_cnt(ej_credit_cnt), .cred_err(ej_cred_err)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with idle inputs, then release it.
    task automatic apply_reset();
        reset_n   = 1'b0;
        in_valid  = '0;
        in_tail   = '0;
        route     = '0;
        credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Reset values. All inputs are active during reset, yet nothing may move.
    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = '1;
        in_tail   = '0;
        route     = '1;
        credit_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (grant !== 5'b00000) $display("[TB] FAIL rst_grant: got %b expected %b", grant, 5'b00000); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b expected %b", out_valid, 1'b0); else passed++;
        total++; if (out_sel !== 3'd0) $display("[TB] FAIL rst_out_sel: got %0d expected %0d", out_sel, 0); else passed++;
        total++; if (credit_cnt !== 3'd4) $display("[TB] FAIL rst_credit_cnt: got %0d expected %0d", credit_cnt, 4); else passed++;
        total++; if (cred_err !== 1'b0) $display("[TB] FAIL rst_cred_err: got %b expected %b", cred_err, 1'b0); else passed++;
        total++; if (ej_grant !== 5'b00000) $display("[TB] FAIL rst_ej_grant: got %b expected %b", ej_grant, 5'b00000); else passed++;
        in_valid  = '0;
        route     = '0;
        credit_in = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Port 2 sends a 3-flit packet. Cycle 1 is the arbitration bubble,
    // cycles 2-4 move flits, and cycle 5 is back in IDLE.
    task automatic test_single_packet();
        logic [4:0] exp_g;
        logic [2:0] exp_c;
        apply_reset();
        route[10 +: 5] = 5'b00001;
        for (int c = 1; c <= 5; c++) begin
            in_valid = (c <= 4) ? 5'b00100 : 5'b00000;
            in_tail  = (c == 4) ? 5'b00100 : 5'b00000;
            exp_g    = (c >= 2 && c <= 4) ? 5'b00100 : 5'b00000;
            exp_c    = (c <= 2) ? 3'd4 : 3'(6 - c);
            @(negedge clk);
            total++; if (grant !== exp_g) $display("[TB] FAIL t1_grant c%0d: got %b expected %b", c, grant, exp_g); else passed++;
            total++; if (out_valid !== (c >= 2 && c <= 4)) $display("[TB] FAIL t1_out_valid c%0d: got %b expected %b", c, out_valid, (c >= 2 && c <= 4)); else passed++;
            total++; if (credit_cnt !== exp_c) $display("[TB] FAIL t1_credit_cnt c%0d: got %0d expected %0d", c, credit_cnt, exp_c); else passed++;
            if (c >= 2) begin
                total++; if (out_sel !== 3'd2) $display("[TB] FAIL t1_out_sel c%0d: got %0d expected %0d", c, out_sel, 2); else passed++;
            end
            step();
        end
    endtask

    // Ports 0, 1 and 3 request this output with single-flit packets. Port 4
    // is valid but routed elsewhere. Each fire is matched by a returned
    // credit, so the count stays full.
    task automatic test_round_robin();
        int         order [4];
        logic [4:0] exp_g;
        order = '{0, 1, 3, 0};
        apply_reset();
        route[0  +: 5] = 5'b00001;
        route[5  +: 5] = 5'b00001;
        route[15 +: 5] = 5'b00001;
        route[20 +: 5] = 5'b00010;
        in_valid = 5'b11011;
        in_tail  = 5'b11111;
        for (int c = 1; c <= 8; c++) begin
            credit_in = (c % 2 == 0);
            exp_g     = (c % 2 == 0) ? 5'(1 << order[c/2 - 1]) : 5'b00000;
            @(negedge clk);
            total++; if (grant !== exp_g) $display("[TB] FAIL t2_grant c%0d: got %b expected %b", c, grant, exp_g); else passed++;
            if (c % 2 == 0) begin
                total++; if (out_sel !== 3'(order[c/2 - 1])) $display("[TB] FAIL t2_out_sel c%0d: got %0d expected %0d", c, out_sel, order[c/2 - 1]); else passed++;
            end
            step();
        end
        in_valid  = '0;
        credit_in = 1'b0;
        @(negedge clk);
        total++; if (credit_cnt !== 3'd4) $display("[TB] FAIL t2_credit_cnt: got %0d expected %0d", credit_cnt, 4); else passed++;
        total++; if (cred_err !== 1'b0) $display("[TB] FAIL t2_cred_err: got %b expected %b", cred_err, 1'b0); else passed++;
        step();
    endtask

    // A 6-flit packet with only 4 credits. It stalls locked, and each
    // returned credit lets exactly one more flit through.
    task automatic test_credit_stall();
        logic [13:1] fires;
        int          exp_cnt [1:13];
        fires   = 13'b0100100011110;
        exp_cnt = '{4, 4, 3, 2, 1, 0, 0, 0, 1, 0, 0, 1, 0};
        apply_reset();
        route[0 +: 5] = 5'b00001;
        for (int c = 1; c <= 13; c++) begin
            in_valid  = (c <= 12) ? 5'b00001 : 5'b00000;
            in_tail   = (c == 12) ? 5'b00001 : 5'b00000;
            credit_in = (c == 8 || c == 11);
            @(negedge clk);
            total++; if (grant !== (fires[c] ? 5'b00001 : 5'b00000)) $display("[TB] FAIL t3_grant c%0d: got %b expected %b", c, grant, (fires[c] ? 5'b00001 : 5'b00000)); else passed++;
            total++; if (out_valid !== fires[c]) $display("[TB] FAIL t3_out_valid c%0d: got %b expected %b", c, out_valid, fires[c]); else passed++;
            total++; if (credit_cnt !== 3'(exp_cnt[c])) $display("[TB] FAIL t3_credit_cnt c%0d: got %0d expected %0d", c, credit_cnt, exp_cnt[c]); else passed++;
            step();
        end
        credit_in = 1'b0;
    endtask

    // A fire and a returned credit in the same cycle leave the count
    // unchanged. A credit returned into a full count raises the sticky error.
    task automatic test_credit_edges();
        int   exp_cnt [1:10];
        logic exp_f;
        exp_cnt = '{4, 4, 3, 2, 2, 2, 3, 4, 4, 4};
        apply_reset();
        route[0 +: 5] = 5'b00001;
        for (int c = 1; c <= 10; c++) begin
            in_valid  = (c <= 5) ? 5'b00001 : 5'b00000;
            in_tail   = (c == 5) ? 5'b00001 : 5'b00000;
            credit_in = (c >= 4 && c <= 8);
            exp_f     = (c >= 2 && c <= 5);
            @(negedge clk);
            total++; if (out_valid !== exp_f) $display("[TB] FAIL t4_out_valid c%0d: got %b expected %b", c, out_valid, exp_f); else passed++;
            total++; if (credit_cnt !== 3'(exp_cnt[c])) $display("[TB] FAIL t4_credit_cnt c%0d: got %0d expected %0d", c, credit_cnt, exp_cnt[c]); else passed++;
            total++; if (cred_err !== (c >= 9)) $display("[TB] FAIL t4_cred_err c%0d: got %b expected %b", c, cred_err, (c >= 9)); else passed++;
            step();
        end
        credit_in = 1'b0;
    endtask

    // A port routed elsewhere is never granted. A reset in the middle of a
    // packet drops the lock and restores the credits at once.
    task automatic test_misroute_and_reset();
        logic [4:0] exp_g;
        apply_reset();
        route[5 +: 5] = 5'b00100;
        in_valid = 5'b00010;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            total++; if (grant !== 5'b00000) $display("[TB] FAIL t5_misroute_grant c%0d: got %b expected %b", c, grant, 5'b00000); else passed++;
            total++; if (out_valid !== 1'b0) $display("[TB] FAIL t5_misroute_valid c%0d: got %b expected %b", c, out_valid, 1'b0); else passed++;
            step();
        end
        route[0 +: 5] = 5'b00001;
        in_valid = 5'b00011;
        for (int c = 5; c <= 7; c++) begin
            exp_g = (c >= 6) ? 5'b00001 : 5'b00000;
            @(negedge clk);
            total++; if (grant !== exp_g) $display("[TB] FAIL t5_grant c%0d: got %b expected %b", c, grant, exp_g); else passed++;
            step();
        end
        reset_n = 1'b0;
        #1;
        total++; if (grant !== 5'b00000) $display("[TB] FAIL t5_rst_grant: got %b expected %b", grant, 5'b00000); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL t5_rst_out_valid: got %b expected %b", out_valid, 1'b0); else passed++;
        total++; if (credit_cnt !== 3'd4) $display("[TB] FAIL t5_rst_credit_cnt: got %0d expected %0d", credit_cnt, 4); else passed++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (grant !== 5'b00000) $display("[TB] FAIL t5_post_rst_idle: got %b expected %b", grant, 5'b00000); else passed++;
        step();
        @(negedge clk);
        total++; if (grant !== 5'b00001) $display("[TB] FAIL t5_post_rst_relock: got %b expected %b", grant, 5'b00001); else passed++;
        step();
        in_valid = '0;
    endtask

    // Eject port: a 10-flit packet streams back to back without credits,
    // and the frozen counter never moves.
    task automatic test_back_to_back();
        logic [4:0] exp_g;
        apply_reset();
        route[15 +: 5] = 5'b10000;
        for (int c = 1; c <= 12; c++) begin
            in_valid = (c <= 11) ? 5'b01000 : 5'b00000;
            in_tail  = (c == 11) ? 5'b01000 : 5'b00000;
            exp_g    = (c >= 2 && c <= 11) ? 5'b01000 : 5'b00000;
            @(negedge clk);
            total++; if (ej_grant !== exp_g) $display("[TB] FAIL t6_ej_grant c%0d: got %b expected %b", c, ej_grant, exp_g); else passed++;
            total++; if (ej_out_valid !== (c >= 2 && c <= 11)) $display("[TB] FAIL t6_ej_out_valid c%0d: got %b expected %b", c, ej_out_valid, (c >= 2 && c <= 11)); else passed++;
            total++; if (ej_credit_cnt !== 3'd4) $display("[TB] FAIL t6_ej_credit_cnt c%0d: got %0d expected %0d", c, ej_credit_cnt, 4); else passed++;
            total++; if (grant !== 5'b00000) $display("[TB] FAIL t6_dir0_grant c%0d: got %b expected %b", c, grant, 5'b00000); else passed++;
            if (c >= 2 && c <= 11) begin
                total++; if (ej_out_sel !== 3'd3) $display("[TB] FAIL t6_ej_out_sel c%0d: got %0d expected %0d", c, ej_out_sel, 3); else passed++;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_credit_stall();
        test_credit_edges();
        test_misroute_and_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
